// File: rtl/demux_pkg.sv
// Shared constants and state type for the demux round-robin scheduler.
package demux_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned SEL_W     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1x8.sv
// One-bit 1-to-8 demultiplexer: routes din onto the output bit chosen by sel.
module demux_1x8
  import demux_pkg::*;
(
  input  logic                 din,
  input  logic [SEL_W-1:0]     sel,
  output logic [NUM_LANES-1:0] dout
);

  always_comb begin
    dout = '0;
    dout[sel] = din;
  end

endmodule

// File: rtl/rr_pick8.sv
// Rotating first-set-bit search over an 8-bit mask, starting at ptr and wrapping 7->0.
module rr_pick8
  import demux_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     sel,
  output logic                 any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = ptr + SEL_W'(i);
      if (!any && mask[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Distributes one valid/ready stream over 8 lanes, round-robin or addressed, holding one item
// in an output register until the chosen lane accepts it.
module demux_rr_scheduler
  import demux_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [NUM_LANES-1:0] en_mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [SEL_W-1:0]     in_dest,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic [DW-1:0]        out_data,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 drop_err,
  output logic [CNT_W-1:0]     sent_cnt
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_sel;
  logic [SEL_W-1:0] dest;
  logic             pick_any;
  logic             can_take;
  logic             sending;
  logic             hs;
  logic             accept;
  logic             dest_ok;

  assign sending  = (state == SEND);
  assign hs       = sending && out_ready[cur_sel];
  // RR mode with an empty mask has nowhere to put an item, so hold the producer off.
  assign can_take = mode || (en_mask != '0);
  assign in_ready = sending ? (out_ready[cur_sel] && can_take) : can_take;
  assign accept   = in_valid && in_ready;

  // A same-cycle accept during SEND searches from the lane after the one completing now.
  assign pick_ptr = sending ? (cur_sel + SEL_W'(1)) : ptr;

  rr_pick8 u_pick (
    .mask (en_mask),
    .ptr  (pick_ptr),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  assign dest    = mode ? in_dest : pick_sel;
  assign dest_ok = mode ? en_mask[in_dest] : pick_any;

  demux_1x8 u_demux (
    .din  (sending),
    .sel  (cur_sel),
    .dout (out_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cur_sel  <= '0;
      out_data <= '0;
      drop_err <= 1'b0;
      sent_cnt <= '0;
    end else begin
      drop_err <= 1'b0;
      if (hs) begin
        sent_cnt <= sent_cnt + CNT_W'(1);
        ptr      <= cur_sel + SEL_W'(1);
        state    <= IDLE;
      end
      if (accept) begin
        if (dest_ok) begin
          state    <= SEND;
          cur_sel  <= dest;
          out_data <= in_data;
        end else begin
          drop_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench for demux_rr_scheduler: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_demux_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [7:0]  en_mask;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_dest;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [7:0]  out_data;
  logic [2:0]  cur_sel;
  logic        drop_err;
  logic [15:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: at most one held item, a next-search pointer, a transfer count.
  bit          held;
  int          h_lane;
  logic [7:0]  h_data;
  int          m_ptr;
  logic [15:0] m_cnt;
  bit          m_drop;
  int          delivered[$];
  logic [7:0]  seen;

  always #5 clk = ~clk;

  demux_rr_scheduler #(.DW(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cur_sel   (cur_sel),
    .drop_err  (drop_err),
    .sent_cnt  (sent_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [7:0] mask, input int p);
    for (int i = 0; i < 8; i++) begin
      if (mask[(p + i) % 8]) return (p + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    held   = 1'b0;
    h_lane = 0;
    h_data = 8'h00;
    m_ptr  = 0;
    m_cnt  = 16'h0;
    m_drop = 1'b0;
  endtask

  // Inputs are set at posedge+1; outputs are compared at the following negedge.
  task automatic step();
    logic [7:0] ev;
    bit can, er, hs, ok;
    int d;
    #4;
    can = mode || (en_mask != 8'h00);
    ev  = held ? 8'(1 << h_lane) : 8'h00;
    er  = held ? (out_ready[h_lane] && can) : can;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("drop_err", 32'(drop_err), 32'(m_drop));
    chk("sent_cnt", 32'(sent_cnt), 32'(m_cnt));
    chk("onehot", 32'($countones(out_valid) <= 1), 32'd1);
    if (held) begin
      chk("out_data", 32'(out_data), 32'(h_data));
      chk("cur_sel", 32'(cur_sel), 32'(h_lane));
    end
    seen |= out_valid;
    m_drop = 1'b0;
    hs = held && out_ready[h_lane];
    if (hs) begin
      delivered.push_back(h_lane);
      m_cnt = m_cnt + 16'd1;
      m_ptr = (h_lane + 1) % 8;
      held  = 1'b0;
    end
    if (in_valid && er) begin
      d  = mode ? int'(in_dest) : rr_pick(en_mask, m_ptr);
      ok = mode ? en_mask[in_dest] : (d >= 0);
      if (ok) begin
        held   = 1'b1;
        h_lane = d;
        h_data = in_data;
      end else begin
        m_drop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp2[4];
    logic [15:0] cnt0;
    rst = 1'b1; mode = 1'b0; en_mask = 8'h00; in_valid = 1'b0;
    in_data = 8'h00; in_dest = 3'd0; out_ready = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_cur_sel", 32'(cur_sel), 32'h0);
    chk("rst_drop_err", 32'(drop_err), 32'h0);
    chk("rst_sent_cnt", 32'(sent_cnt), 32'h0);
    rst = 1'b0;

    // 1: RR over all lanes, back-to-back
    delivered.delete();
    mode = 1'b0; en_mask = 8'hFF; out_ready = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'hD0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t1_cnt", 32'(sent_cnt), 32'd10);
    chk("t1_n", 32'(delivered.size()), 32'd10);
    for (int i = 0; i < 10 && i < delivered.size(); i++) chk("t1_lane", 32'(delivered[i]), 32'(i % 8));

    // 2: RR over a sparse mask from ptr=0
    apply_reset();
    delivered.delete();
    seen = 8'h00;
    exp2 = '{2, 5, 7, 2};
    en_mask = 8'b1010_0100; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h20 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t2_n", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < 4 && i < delivered.size(); i++) chk("t2_lane", 32'(delivered[i]), 32'(exp2[i]));
    chk("t2_never", 32'(seen & 8'b0101_1011), 32'h0);

    // 3: addressed item stalled by its lane
    mode = 1'b1; en_mask = 8'hFF; out_ready = 8'h00; in_dest = 3'd3; in_data = 8'h3C;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", 32'(out_valid), 32'h08);
      chk("t3_data", 32'(out_data), 32'h3C);
      chk("t3_ready", 32'(in_ready), 32'h0);
      step();
    end
    cnt0 = m_cnt;
    out_ready = 8'h08;
    step();
    chk("t3_done", 32'(sent_cnt), 32'(cnt0 + 16'd1));
    chk("t3_idle", 32'(out_valid), 32'h0);

    // 4: addressed item for a disabled lane is dropped
    out_ready = 8'hFF; en_mask = 8'hBF; in_dest = 3'd6; in_data = 8'h66; in_valid = 1'b1;
    cnt0 = m_cnt;
    step();
    in_valid = 1'b0;
    chk("t4_drop", 32'(drop_err), 32'h1);
    chk("t4_valid", 32'(out_valid), 32'h0);
    step();
    chk("t4_pulse", 32'(drop_err), 32'h0);
    chk("t4_cnt", 32'(sent_cnt), 32'(cnt0));
    step();

    // 5: RR with empty mask stalls, then lane 4 opens
    mode = 1'b0; en_mask = 8'h00; in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 4; i++) step();
    chk("t5_stall", 32'(out_valid), 32'h0);
    en_mask = 8'h10;
    step();
    in_valid = 1'b0;
    chk("t5_lane4", 32'(out_valid), 32'h10);
    step(); step();

    // 6: reset while an item is held for lane 5
    en_mask = 8'h20; out_ready = 8'hFF; in_valid = 1'b1; in_data = 8'hA5;
    step();
    out_ready = 8'h00; in_data = 8'hA6;
    step();
    in_valid = 1'b0;
    step();
    chk("t6_held", 32'(out_valid), 32'h20);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_cnt", 32'(sent_cnt), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    en_mask = 8'h0C; out_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    chk("t6_first", 32'(cur_sel), 32'd2);
    chk("t6_first_v", 32'(out_valid), 32'h04);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      en_mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_dest   = 3'($urandom);
      out_ready = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
